// File: rtl/urgency_blinker.sv
// Multi-channel countdown blinker: shared urgency level from timer_value/max_time,
// per-channel OFF/SOLID/URGENCY/BURST indicators. BURST is built only with `BLINK_BURST_EN.
module urgency_blinker #(
  parameter int CH      = 4,
  parameter int TW      = 8,
  parameter int CW      = 16,
  parameter int SLOW    = 1000,
  parameter int MID     = 500,
  parameter int FAST    = 200,
  parameter int BURST_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [CH-1:0]     enable,
  input  logic [2*CH-1:0]   mode,
  input  logic [TW-1:0]     timer_value,
  input  logic [TW-1:0]     max_time,
  output logic [CH-1:0]     led,
  output logic [1:0]        level,
  output logic              expired,
  output logic [CH-1:0]     busy
);

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_SOLID = 2'b01;
`ifdef BLINK_BURST_EN
  localparam logic [1:0] M_BURST = 2'b11;
`endif

  logic [TW-1:0] rem;
  logic [TW-1:0] third;
  logic [TW:0]   third2;
  logic [1:0]    level_nxt;
  logic [CW-1:0] thr;

  // Remaining time saturates at zero so an overrun never wraps back to a slow level.
  always_comb begin
    rem    = (timer_value >= max_time) ? '0 : max_time - timer_value;
    third  = max_time / TW'(3);
    third2 = {third, 1'b0};
    if (max_time == '0 || rem == '0)
      level_nxt = 2'd3;
    else if (rem <= third)
      level_nxt = 2'd2;
    else if ({1'b0, rem} <= third2)
      level_nxt = 2'd1;
    else
      level_nxt = 2'd0;
  end

  always_comb begin
    case (level)
      2'd0:    thr = CW'(SLOW);
      2'd1:    thr = CW'(MID);
      default: thr = CW'(FAST);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 2'd0;
      expired <= 1'b0;
    end else begin
      level   <= level_nxt;
      expired <= (level_nxt == 2'd3) && (level != 2'd3);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [1:0]    md;
    logic [1:0]    prev_mode;
    logic          prev_en;
    logic          restart;
    logic          led_r;
    logic          hold;
    logic [CW-1:0] cnt;

    assign md      = mode[2*i +: 2];
    assign restart = enable[i] && (!prev_en || md != prev_mode);
    assign led[i]  = led_r;

`ifdef BLINK_BURST_EN
    localparam int FW = $clog2(2*BURST_N + 1);
    logic          busy_r;
    logic [FW-1:0] flash;
    assign busy[i] = busy_r;
`else
    assign busy[i] = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt       <= '0;
        led_r     <= 1'b0;
        hold      <= 1'b0;
        prev_en   <= 1'b0;
        prev_mode <= 2'b00;
`ifdef BLINK_BURST_EN
        busy_r    <= 1'b0;
        flash     <= '0;
`endif
      end else begin
        prev_en   <= enable[i];
        prev_mode <= md;
        if (!enable[i]) begin
          cnt   <= '0;
          led_r <= 1'b0;
          hold  <= 1'b0;
`ifdef BLINK_BURST_EN
          busy_r <= 1'b0;
          flash  <= '0;
`endif
        end else if (restart) begin
          // A restart swallows any tick in the same cycle.
          cnt   <= '0;
          led_r <= 1'b0;
          hold  <= 1'b0;
`ifdef BLINK_BURST_EN
          busy_r <= (md == M_BURST);
          flash  <= '0;
`endif
        end else begin
          case (md)
            M_OFF: begin
              led_r <= 1'b0;
              cnt   <= '0;
              hold  <= 1'b0;
            end
            M_SOLID: begin
              led_r <= 1'b1;
              cnt   <= '0;
              hold  <= 1'b0;
            end
`ifdef BLINK_BURST_EN
            M_BURST: begin
              hold <= 1'b0;
              if (!busy_r) begin
                led_r <= 1'b0;
                cnt   <= '0;
              end else if (tick) begin
                if (cnt >= CW'(FAST)) begin
                  cnt   <= '0;
                  flash <= flash + 1'b1;
                  if (flash == FW'(2*BURST_N - 1)) begin
                    busy_r <= 1'b0;
                    led_r  <= 1'b0;
                  end else begin
                    led_r <= ~led_r;
                  end
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
            end
`endif
            default: begin
              // hold marks a solid-expired period so blinking resumes from dark.
              if (level == 2'd3) begin
                led_r <= 1'b1;
                cnt   <= '0;
                hold  <= 1'b1;
              end else if (hold) begin
                led_r <= 1'b0;
                cnt   <= '0;
                hold  <= 1'b0;
              end else if (tick) begin
                if (cnt >= thr) begin
                  cnt   <= '0;
                  led_r <= ~led_r;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_urgency_blinker.sv
// Self-checking bench for urgency_blinker: level table, directed blink/expiry/burst/reset
// sequences, then random stimulus against a rule-level reference model.
module tb_urgency_blinker;
  localparam int CH = 2, TW = 8, CW = 16, SLOW = 9, MID = 4, FAST = 1, BURST_N = 2;
`ifdef BLINK_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic            clk, rst, tick, expired;
  logic [CH-1:0]   enable, led, busy;
  logic [2*CH-1:0] mode;
  logic [TW-1:0]   timer_value, max_time;
  logic [1:0]      level;

  int n_checks = 0;
  int n_fail   = 0;

  urgency_blinker #(.CH(CH), .TW(TW), .CW(CW), .SLOW(SLOW), .MID(MID), .FAST(FAST),
                    .BURST_N(BURST_N)) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .mode(mode),
    .timer_value(timer_value), .max_time(max_time),
    .led(led), .level(level), .expired(expired), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles between two consecutive changes of led[c]; first change is only a sync point.
  task automatic measure(input int c, input int exp, input string name);
    logic v;
    int n;
    v = led[c]; n = 0;
    while (led[c] == v && n < 50) begin @(negedge clk); n++; end
    v = led[c]; n = 0;
    while (led[c] == v && n < 50) begin @(negedge clk); n++; end
    check(name, n, exp);
  endtask

  // ---------------- reference model ----------------
  int         m_level;
  bit         m_exp;
  bit         m_led [CH];
  bit         m_busy[CH];
  bit         m_pen [CH];
  bit         m_hold[CH];
  int         m_cnt [CH];
  int         m_flash[CH];
  logic [1:0] m_pmode[CH];

  function automatic int ref_level(input int tv, input int mt);
    int r, t;
    r = (tv >= mt) ? 0 : mt - tv;
    t = mt / 3;
    if (mt == 0 || r == 0) return 3;
    if (r <= t) return 2;
    if (r <= 2 * t) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    int thr, nl;
    bit en, is_burst;
    logic [1:0] md;
    if (rst) begin
      m_level = 0; m_exp = 0;
      for (int c = 0; c < CH; c++) begin
        m_led[c] = 0; m_busy[c] = 0; m_pen[c] = 0; m_hold[c] = 0;
        m_cnt[c] = 0; m_flash[c] = 0; m_pmode[c] = 2'b00;
      end
    end else begin
      thr = (m_level == 0) ? SLOW : (m_level == 1) ? MID : FAST;
      nl  = ref_level(int'(timer_value), int'(max_time));
      for (int c = 0; c < CH; c++) begin
        en = enable[c];
        md = mode[2*c +: 2];
        is_burst = (md == 2'b11) && BURST_ON;
        if (!en) begin
          m_led[c] = 0; m_busy[c] = 0; m_cnt[c] = 0; m_flash[c] = 0; m_hold[c] = 0;
        end else if (!m_pen[c] || md != m_pmode[c]) begin
          m_led[c] = 0; m_cnt[c] = 0; m_flash[c] = 0; m_hold[c] = 0; m_busy[c] = is_burst;
        end else if (md == 2'b00) begin
          m_led[c] = 0; m_cnt[c] = 0;
        end else if (md == 2'b01) begin
          m_led[c] = 1; m_cnt[c] = 0;
        end else if (is_burst) begin
          if (!m_busy[c]) begin
            m_led[c] = 0; m_cnt[c] = 0;
          end else if (tick) begin
            if (m_cnt[c] >= FAST) begin
              m_cnt[c] = 0;
              m_flash[c]++;
              m_led[c] = !m_led[c];
              if (m_flash[c] == 2 * BURST_N) begin m_busy[c] = 0; m_led[c] = 0; end
            end else m_cnt[c]++;
          end
        end else begin
          if (m_level == 3) begin
            m_led[c] = 1; m_cnt[c] = 0; m_hold[c] = 1;
          end else if (m_hold[c]) begin
            m_led[c] = 0; m_cnt[c] = 0; m_hold[c] = 0;
          end else if (tick) begin
            if (m_cnt[c] >= thr) begin m_cnt[c] = 0; m_led[c] = !m_led[c]; end
            else m_cnt[c]++;
          end
        end
        m_pen[c] = en;
        m_pmode[c] = md;
      end
      m_exp   = (nl == 3) && (m_level != 3);
      m_level = nl;
    end
  end

  typedef struct {
    logic [TW-1:0] tv;
    logic [TW-1:0] mt;
    int            lvl;
  } lvl_vec_t;

  lvl_vec_t   vt[16];
  logic [11:0] burst_busy_exp, burst_led_exp;

  initial begin
    int prev, first_hi;
    vt[0]  = '{8'd0,   8'd30,  0};
    vt[1]  = '{8'd9,   8'd30,  0};
    vt[2]  = '{8'd10,  8'd30,  1};
    vt[3]  = '{8'd19,  8'd30,  1};
    vt[4]  = '{8'd20,  8'd30,  2};
    vt[5]  = '{8'd29,  8'd30,  2};
    vt[6]  = '{8'd30,  8'd30,  3};
    vt[7]  = '{8'd40,  8'd30,  3};
    vt[8]  = '{8'd0,   8'd0,   3};
    vt[9]  = '{8'd0,   8'd2,   0};
    vt[10] = '{8'd1,   8'd2,   0};
    vt[11] = '{8'd2,   8'd2,   3};
    vt[12] = '{8'd0,   8'd255, 0};
    vt[13] = '{8'd85,  8'd255, 1};
    vt[14] = '{8'd170, 8'd255, 2};
    vt[15] = '{8'd0,   8'd30,  0};
`ifdef BLINK_BURST_EN
    burst_busy_exp = 12'h0FF;
    burst_led_exp  = 12'h0CC;
`else
    burst_busy_exp = 12'h000;
    burst_led_exp  = 12'hC00;
`endif

    // reset state
    rst = 1'b1; tick = 1'b1; enable = '0; mode = '0; timer_value = 8'd0; max_time = 8'd30;
    repeat (2) @(negedge clk);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(level), 0);
    check("rst_expired", int'(expired), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_level", int'(level), 0);

    // level table with channels disabled
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      timer_value = vt[i].tv; max_time = vt[i].mt;
      @(negedge clk);
      check($sformatf("tbl%0d_level", i), int'(level), vt[i].lvl);
      check($sformatf("tbl%0d_expired", i), int'(expired), (vt[i].lvl == 3 && prev != 3) ? 1 : 0);
      check($sformatf("tbl%0d_led", i), int'(led), 0);
      prev = vt[i].lvl;
    end

    // urgency stepping on ch0
    mode = 4'b0010; enable = 2'b01;
    repeat (2) @(negedge clk);
    check("lvl0", int'(level), 0);
    measure(0, 10, "period_lvl0_a");
    measure(0, 10, "period_lvl0_b");
    timer_value = 8'd11;
    repeat (2) @(negedge clk);
    check("lvl1", int'(level), 1);
    measure(0, 5, "period_lvl1_a");
    measure(0, 5, "period_lvl1_b");
    timer_value = 8'd20;
    repeat (2) @(negedge clk);
    check("lvl2", int'(level), 2);
    measure(0, 2, "period_lvl2_a");
    measure(0, 2, "period_lvl2_b");
    timer_value = 8'd30;
    @(negedge clk);
    check("lvl3", int'(level), 3);
    check("expired_pulse", int'(expired), 1);
    @(negedge clk);
    check("expired_one_clk", int'(expired), 0);
    check("lvl3_led_solid", int'(led[0]), 1);
    timer_value = 8'd40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sat_no_reexpire", int'(expired), 0);
    end
    check("sat_level", int'(level), 3);
    check("sat_led_solid", int'(led[0]), 1);

    // ch1 SOLID -> OFF, then disable / re-enable in URGENCY
    mode[3:2] = 2'b01; enable[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("solid_on", int'(led[1]), 1);
    repeat (3) @(negedge clk);
    mode[3:2] = 2'b00;
    @(negedge clk);
    check("off_after_change", int'(led[1]), 0);
    enable[1] = 1'b0; mode[3:2] = 2'b10; timer_value = 8'd0;
    repeat (3) @(negedge clk);
    check("disabled_led", int'(led[1]), 0);
    check("back_to_lvl0", int'(level), 0);
    enable[1] = 1'b1;
    first_hi = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (first_hi < 0 && led[1]) first_hi = k;
    end
    check("reenable_first_toggle", first_hi, 10);

    // burst on ch1
    mode[3:2] = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("burst_busy_k%0d", k), int'(busy[1]), int'(burst_busy_exp[k]));
      check($sformatf("burst_led_k%0d", k), int'(led[1]), int'(burst_led_exp[k]));
    end

    // reset during level 3 and mid-burst
    timer_value = 8'd30;
    repeat (3) @(negedge clk);
    check("pre_rst_level3", int'(level), 3);
    mode[3:2] = 2'b10;
    @(negedge clk);
    mode[3:2] = 2'b11;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", int'(busy[1]), BURST_ON ? 1 : 0);
    rst = 1'b1;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_level", int'(level), 0);
    check("async_rst_expired", int'(expired), 0);
    timer_value = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_level", int'(level), 0);
    check("rel_expired", int'(expired), 0);
    repeat (2) @(negedge clk);
    check("rel_expired_later", int'(expired), 0);

    // random stimulus against the model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        check($sformatf("rnd_led%0d", c), int'(led[c]), int'(m_led[c]));
        check($sformatf("rnd_busy%0d", c), int'(busy[c]), int'(m_busy[c]));
      end
      check("rnd_level", int'(level), m_level);
      check("rnd_expired", int'(expired), int'(m_exp));
      rst  = ($urandom_range(0, 299) == 0);
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) enable[$urandom_range(0, CH-1)] ^= 1'b1;
      if ($urandom_range(0, 14) == 0) begin
        int c;
        c = $urandom_range(0, CH-1);
        mode[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 39) == 0) max_time = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0) timer_value = 8'($urandom_range(0, int'(max_time) + 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
